// File: rtl/eth_rst_seq_pkg.sv
// Shared types and default timing constants for the multi-channel reset sequencer.
package eth_rst_seq_pkg;

  typedef enum logic [1:0] {
    StAssert  = 2'd0,
    StRelease = 2'd1,
    StDone    = 2'd2
  } state_e;

  // 50 MHz board build
  localparam int unsigned AssertCycles50M = 2000000;
  localparam int unsigned StepCycles50M   = 500000;
  localparam int unsigned DebCycles50M    = 500000;

  // Shortened simulation build
  localparam int unsigned AssertCyclesSim = 200;
  localparam int unsigned StepCyclesSim   = 50;
  localparam int unsigned DebCyclesSim    = 20;

endpackage

// File: rtl/eth_rst_seq_btn_sync_debounce.sv
// Button 2-FF synchroniser with optional stability filter (enabled by RST_SEQ_DEBOUNCE_EN).
module btn_sync_debounce #(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic btn_pressed
);

  logic [1:0] sync_q;

  // Reset to 1 so the button reads as released.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], btn_n};
  end

`ifdef RST_SEQ_DEBOUNCE_EN
  logic             pressed_q, pressed_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;

  // Counter only runs while the synced level disagrees; any bounce back clears it.
  always_comb begin
    pressed_d = pressed_q;
    deb_cnt_d = '0;
    if (~sync_q[1] != pressed_q) begin
      if (deb_cnt_q == CNT_W'(DEB_CYCLES - 1)) pressed_d = ~sync_q[1];
      else                                     deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pressed_q <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      pressed_q <= pressed_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign btn_pressed = pressed_q;
`else
  assign btn_pressed = ~sync_q[1];
`endif

endmodule

// File: rtl/eth_rst_seq.sv
// Multi-channel reset sequencer: hold all outputs low, then release them in index order.
// Define RST_SEQ_DEBOUNCE_EN to filter the board button.
module eth_rst_seq
  import eth_rst_seq_pkg::*;
#(
  parameter int unsigned NUM_CH        = 3,
  parameter int unsigned ASSERT_CYCLES = AssertCycles50M,
  parameter int unsigned STEP_CYCLES   = StepCycles50M,
  parameter int unsigned DEB_CYCLES    = DebCycles50M,
  parameter int unsigned CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_n,
  input  logic              soft_req,
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IdxW = $clog2(NUM_CH) + 1;

  logic btn_pressed;
  logic trig;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [NUM_CH-1:0] rst_n_q, rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  btn_sync_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_btn (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (btn_n),
    .btn_pressed (btn_pressed)
  );

  assign trig = rst | btn_pressed | soft_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    busy_d  = busy_q;
    done_d  = done_q;
    // A trigger overrides every other transition and restarts from scratch.
    if (trig) begin
      state_d = StAssert;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        StAssert: begin
          if (cnt_q == CNT_W'(ASSERT_CYCLES - 1)) begin
            rst_n_d[0] = 1'b1;
            cnt_d      = '0;
            if (NUM_CH == 1) begin
              state_d = StDone;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = StRelease;
              idx_d   = IdxW'(1);
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRelease: begin
          if (cnt_q == CNT_W'(STEP_CYCLES - 1)) begin
            rst_n_d[idx_q] = 1'b1;
            cnt_d          = '0;
            if (idx_q == IdxW'(NUM_CH - 1)) begin
              state_d = StDone;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDone: begin
        end
        default: begin
          state_d = StAssert;
          cnt_d   = '0;
          idx_d   = '0;
          rst_n_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAssert;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rst_n_out = rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_eth_rst_seq.sv
// Directed bench for eth_rst_seq: 3-channel instance plus a 1-channel instance on shared inputs.
module tb_eth_rst_seq;
  import eth_rst_seq_pkg::*;

`ifdef RST_SEQ_DEBOUNCE_EN
  localparam int DL = DebCyclesSim;
`else
  localparam int DL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_n = 1'b1;
  logic       soft_req = 1'b0;
  logic [2:0] rst_n_out;
  logic       busy, done;
  logic [0:0] rst_n_out1;
  logic       busy1, done1;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  eth_rst_seq #(
    .NUM_CH        (3),
    .ASSERT_CYCLES (AssertCyclesSim),
    .STEP_CYCLES   (StepCyclesSim),
    .DEB_CYCLES    (DebCyclesSim),
    .CNT_W         (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_n),
    .soft_req  (soft_req),
    .rst_n_out (rst_n_out),
    .busy      (busy),
    .done      (done)
  );

  eth_rst_seq #(
    .NUM_CH        (1),
    .ASSERT_CYCLES (AssertCyclesSim),
    .STEP_CYCLES   (StepCyclesSim),
    .DEB_CYCLES    (DebCyclesSim),
    .CNT_W         (32)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_n),
    .soft_req  (soft_req),
    .rst_n_out (rst_n_out1),
    .busy      (busy1),
    .done      (done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected 3-channel outputs n edges after the last trigger edge.
  function automatic logic [2:0] exp_out(int n);
    if (n >= 300)      return 3'b111;
    else if (n >= 250) return 3'b011;
    else if (n >= 200) return 3'b001;
    else               return 3'b000;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (rst_n_out !== 3'b000 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got out=%b busy=%b done=%b, want 000 1 0", rst_n_out, busy, done);
    end
    rst = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      tick();
      n_checks++;
      if (rst_n_out !== exp_out(n) || busy !== (n < 300) || done !== (n >= 300)) begin
        n_fail++;
        $display("FAIL reset_seq n=%0d: got out=%b busy=%b done=%b, want out=%b busy=%b done=%b",
                 n, rst_n_out, busy, done, exp_out(n), n < 300, n >= 300);
      end
      n_checks++;
      if (rst_n_out1 !== 1'(n >= 200) || busy1 !== (n < 200) || done1 !== (n >= 200)) begin
        n_fail++;
        $display("FAIL one_ch_seq n=%0d: got out=%b busy=%b done=%b, want out=%b done=%b",
                 n, rst_n_out1, busy1, done1, n >= 200, n >= 200);
      end
    end
  endtask

  task automatic test_soft_req();
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    n_checks++;
    if (rst_n_out !== 3'b000 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL soft_req_restart: got out=%b busy=%b done=%b, want 000 1 0", rst_n_out, busy, done);
    end
    for (int n = 1; n <= 300; n++) begin
      tick();
      n_checks++;
      if (rst_n_out !== exp_out(n) || busy !== (n < 300) || done !== (n >= 300)) begin
        n_fail++;
        $display("FAIL soft_req_seq n=%0d: got out=%b busy=%b done=%b, want out=%b",
                 n, rst_n_out, busy, done, exp_out(n));
      end
    end
  endtask

  task automatic test_soft_req_mid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (248) tick();
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    n_checks++;
    if (rst_n_out !== 3'b000 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL soft_req_mid_drop: got out=%b busy=%b done=%b, want 000 1 0", rst_n_out, busy, done);
    end
    for (int n = 1; n <= 300; n++) begin
      tick();
      n_checks++;
      if (rst_n_out !== exp_out(n) || busy !== (n < 300) || done !== (n >= 300)) begin
        n_fail++;
        $display("FAIL soft_req_mid_seq n=%0d: got out=%b, want %b", n, rst_n_out, exp_out(n));
      end
    end
  endtask

  // Starts from DONE. Press for 100 cycles; trigger ends 2 sync (+DL filter) cycles after release.
  task automatic test_button();
    logic [2:0] exp;
    btn_n = 1'b0;
    for (int k = 1; k <= 102 + DL; k++) begin
      tick();
      if (k == 100) btn_n = 1'b1;
      exp = (k <= 2 + DL) ? 3'b111 : 3'b000;
      n_checks++;
      if (rst_n_out !== exp) begin
        n_fail++;
        $display("FAIL button_hold k=%0d: got out=%b, want %b", k, rst_n_out, exp);
      end
    end
    for (int n = 1; n <= 300; n++) begin
      tick();
      n_checks++;
      if (rst_n_out !== exp_out(n) || done !== (n >= 300)) begin
        n_fail++;
        $display("FAIL button_seq n=%0d: got out=%b done=%b, want out=%b", n, rst_n_out, done, exp_out(n));
      end
    end
  endtask

  // Starts from DONE. Three 5-cycle glitches, 10 cycles apart.
  task automatic test_glitch();
    logic [2:0] exp;
    for (int k = 1; k <= 30; k++) begin
      btn_n = ((k - 1) % 10) >= 5;
      tick();
`ifdef RST_SEQ_DEBOUNCE_EN
      exp = 3'b111;
`else
      exp = (k >= 3) ? 3'b000 : 3'b111;
`endif
      n_checks++;
      if (rst_n_out !== exp) begin
        n_fail++;
        $display("FAIL glitch k=%0d: got out=%b, want %b", k, rst_n_out, exp);
      end
    end
    btn_n = 1'b1;
`ifdef RST_SEQ_DEBOUNCE_EN
    btn_n = 1'b0;
    for (int k = 1; k <= 2 + DL + 1; k++) begin
      tick();
      exp = (k <= 2 + DL) ? 3'b111 : 3'b000;
      n_checks++;
      if (rst_n_out !== exp) begin
        n_fail++;
        $display("FAIL debounced_press k=%0d: got out=%b, want %b", k, rst_n_out, exp);
      end
    end
    btn_n = 1'b1;
    repeat (40) tick();
`endif
  endtask

  task automatic test_rst_mid_release();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (220) tick();
    n_checks++;
    if (rst_n_out !== 3'b001 || rst_n_out1 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_release_pre: got out=%b out1=%b, want 001 1", rst_n_out, rst_n_out1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (rst_n_out !== 3'b000 || busy !== 1'b1 || done !== 1'b0 ||
        rst_n_out1 !== 1'b0 || busy1 !== 1'b1 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_release_rst: got out=%b busy=%b done=%b out1=%b busy1=%b done1=%b, want all reset",
               rst_n_out, busy, done, rst_n_out1, busy1, done1);
    end
    for (int n = 1; n <= 300; n++) begin
      tick();
      n_checks++;
      if (rst_n_out !== exp_out(n) || rst_n_out1 !== 1'(n >= 200) || done1 !== (n >= 200)) begin
        n_fail++;
        $display("FAIL mid_release_seq n=%0d: got out=%b out1=%b done1=%b, want out=%b",
                 n, rst_n_out, rst_n_out1, done1, exp_out(n));
      end
    end
  endtask

  initial begin
    test_reset();
    test_soft_req();
    test_soft_req_mid();
    test_button();
    test_glitch();
    test_rst_mid_release();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
